// File: rtl/alu_pipe_if.sv
// Valid/ready operand and result bundle for alu_pipe.
// Slave side is the ALU and master side is the issuing logic.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [2:0]       flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_err, flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_err, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: issue register S1, result register S2 with {Z,V,N} flags.
// Define ALU_PIPE_MUL_EN to enable the iterative signed multiply on opcode 4'hA.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned NBYTE = 2 * WIDTH / 8;
  localparam int unsigned NNIB  = WIDTH / 4;

  localparam logic [3:0] OpAdd    = 4'h0;
  localparam logic [3:0] OpSub    = 4'h1;
  localparam logic [3:0] OpXor    = 4'h2;
  localparam logic [3:0] OpRed    = 4'h3;
  localparam logic [3:0] OpSll    = 4'h4;
  localparam logic [3:0] OpSra    = 4'h5;
  localparam logic [3:0] OpRor    = 4'h6;
  localparam logic [3:0] OpPaddsb = 4'h7;
  localparam logic [3:0] OpLlb    = 4'h8;
  localparam logic [3:0] OpLhb    = 4'h9;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OpMul    = 4'hA;
`endif

  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       s1_op;
  logic             s1_go, op_done;

  logic             out_valid_q, out_err_q;
  logic [WIDTH-1:0] out_result_q;
  logic [2:0]       flags_q;

  logic [WIDTH-1:0] res;
  logic             err, v, upd_z, upd_vn;

  logic [WIDTH-1:0]   add_r, sub_r, red_r, pad_r, sll_r, sra_r, ror_r;
  logic               add_ov, sub_ov;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] ab;
  logic [4:0]         nib;

  assign s1_go        = s1_valid && op_done && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_go;

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  assign bus.flags      = flags_q;

  // Saturation only on same-sign add / opposite-sign subtract that flips sign.
  assign add_r  = s1_a + s1_b;
  assign sub_r  = s1_a - s1_b;
  assign add_ov = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_r[WIDTH-1] != s1_a[WIDTH-1]);
  assign sub_ov = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_r[WIDTH-1] != s1_a[WIDTH-1]);

  assign amt   = s1_b[SHW-1:0];
  assign sll_r = s1_a << amt;
  assign sra_r = WIDTH'($signed(s1_a) >>> amt);
  assign ror_r = (s1_a >> amt) | (s1_a << (WIDTH - 32'(amt)));
  assign ab    = {s1_b, s1_a};

  always_comb begin
    red_r = '0;
    for (int i = 0; i < NBYTE; i++) begin
      red_r = red_r + WIDTH'($signed(ab[8*i +: 8]));
    end
  end

  always_comb begin
    pad_r = '0;
    nib   = '0;
    for (int j = 0; j < NNIB; j++) begin
      nib = {s1_a[4*j+3], s1_a[4*j +: 4]} + {s1_b[4*j+3], s1_b[4*j +: 4]};
      if (nib[4] != nib[3]) pad_r[4*j +: 4] = nib[4] ? 4'h8 : 4'h7;
      else                  pad_r[4*j +: 4] = nib[3:0];
    end
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {MulIdle, MulIter, MulDone} mul_st_e;

  mul_st_e            mul_st;
  logic [SHW-1:0]     mul_cnt;
  logic [2*WIDTH-1:0] mul_acc, mul_mc, mul_mc_cur, mul_acc_cur, mul_addend, mul_step;
  logic [WIDTH-1:0]   mul_mp, mul_mp_cur;
  logic               mul_last, mul_ovf;

  // The first iteration runs straight from S1 so the product is ready after WIDTH edges.
  assign mul_mc_cur  = (mul_st == MulIdle) ? (2*WIDTH)'($signed(s1_a)) : mul_mc;
  assign mul_mp_cur  = (mul_st == MulIdle) ? s1_b : mul_mp;
  assign mul_acc_cur = (mul_st == MulIdle) ? '0 : mul_acc;
  assign mul_addend  = mul_mp_cur[0] ? mul_mc_cur : '0;
  assign mul_last    = (mul_st == MulIter) && (mul_cnt == SHW'(WIDTH - 1));
  // The multiplier sign bit carries weight -2^(WIDTH-1).
  assign mul_step    = mul_last ? (mul_acc_cur - mul_addend) : (mul_acc_cur + mul_addend);
  assign mul_ovf     = !((&mul_acc[2*WIDTH-1:WIDTH-1]) || !(|mul_acc[2*WIDTH-1:WIDTH-1]));
  assign op_done     = (s1_op != OpMul) || (mul_st == MulDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_st  <= MulIdle;
      mul_cnt <= '0;
      mul_acc <= '0;
      mul_mc  <= '0;
      mul_mp  <= '0;
    end else begin
      unique case (mul_st)
        MulIdle: begin
          if (s1_valid && (s1_op == OpMul)) begin
            mul_acc <= mul_step;
            mul_mc  <= mul_mc_cur << 1;
            mul_mp  <= mul_mp_cur >> 1;
            mul_cnt <= SHW'(1);
            mul_st  <= MulIter;
          end
        end
        MulIter: begin
          mul_acc <= mul_step;
          mul_mc  <= mul_mc_cur << 1;
          mul_mp  <= mul_mp_cur >> 1;
          mul_cnt <= mul_cnt + SHW'(1);
          if (mul_last) mul_st <= MulDone;
        end
        MulDone: begin
          if (s1_go) mul_st <= MulIdle;
        end
        default: mul_st <= MulIdle;
      endcase
    end
  end
`else
  assign op_done = 1'b1;
`endif

  always_comb begin
    res    = '0;
    err    = 1'b0;
    v      = 1'b0;
    upd_z  = 1'b0;
    upd_vn = 1'b0;
    case (s1_op)
      OpAdd: begin
        v      = add_ov;
        res    = add_ov ? (s1_a[WIDTH-1] ? SatMin : SatMax) : add_r;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OpSub: begin
        v      = sub_ov;
        res    = sub_ov ? (s1_a[WIDTH-1] ? SatMin : SatMax) : sub_r;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OpXor: begin
        res   = s1_a ^ s1_b;
        upd_z = 1'b1;
      end
      OpRed:    res = red_r;
      OpSll: begin
        res   = sll_r;
        upd_z = 1'b1;
      end
      OpSra: begin
        res   = sra_r;
        upd_z = 1'b1;
      end
      OpRor: begin
        res   = ror_r;
        upd_z = 1'b1;
      end
      OpPaddsb: res = pad_r;
      OpLlb:    res = (s1_a & ({WIDTH{1'b1}} << 8)) | WIDTH'(s1_b[7:0]);
      OpLhb:    res = (s1_a & ({WIDTH{1'b1}} >> 8)) | (WIDTH'(s1_b[7:0]) << (WIDTH - 8));
`ifdef ALU_PIPE_MUL_EN
      OpMul: begin
        res    = mul_acc[WIDTH-1:0];
        v      = mul_ovf;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
`endif
      default:  err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_op    <= bus.in_op;
    end else if (s1_go) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      flags_q      <= '0;
    end else if (s1_go) begin
      out_valid_q  <= 1'b1;
      out_result_q <= res;
      out_err_q    <= err;
      if (upd_z) flags_q[2] <= (res == '0);
      if (upd_vn) begin
        flags_q[1] <= v;
        flags_q[0] <= res[WIDTH-1];
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule
